// File: rtl/exp6_constantes.sv
// Shared constants for the move detector: state codes and debounce default.
// Imported by the control unit and its testbench.
package exp6_constantes;

  localparam int N_DEBOUNCE_PADRAO = 4;
  localparam int LARGURA_CONT = 8;

  typedef enum logic [2:0] {
    OCIOSO          = 3'd0,
    FILTRANDO       = 3'd1,
    REGISTRA        = 3'd2,
    AGUARDA_SOLTURA = 3'd3,
    FILTRA_SOLTURA  = 3'd4
  } estado_t;

  localparam logic [2:0] DB_ILEGAL = 3'd7;

  function automatic logic one_hot4(
    input logic [3:0] v
  );
    return (v != 4'd0) &&
           ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/exp6_detector_jogada_if.sv
// Player-side bundle: raw buttons and enable in,
// accepted move, pulse and debug state out.
interface exp6_detector_jogada_if;

  logic [3:0] botoes;
  logic       habilita;
  logic       tem_jogada;
  logic [3:0] jogada;
  logic [2:0] db_estado;

  modport master (
    output botoes,
    output habilita,
    input  tem_jogada,
    input  jogada,
    input  db_estado
  );

  modport slave (
    input  botoes,
    input  habilita,
    output tem_jogada,
    output jogada,
    output db_estado
  );

endinterface

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer for asynchronous inputs.
// Synchronous active-high reset clears both stages.
module sincronizador_2ff #(
  parameter int LARGURA = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LARGURA-1:0] d,
  output logic [LARGURA-1:0] q
);

  logic [LARGURA-1:0] meta;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/exp6_detector_jogada.sv
// Debounced move detector: accepts one one-hot button press,
// then demands a debounced release before the next one.
module exp6_detector_jogada
  import exp6_constantes::*;
#(
  parameter int N_DEBOUNCE = N_DEBOUNCE_PADRAO
) (
  input logic clock,
  input logic reset,
  exp6_detector_jogada_if.slave bus
);

  localparam logic [LARGURA_CONT-1:0] CONT_MAX =
    LARGURA_CONT'(N_DEBOUNCE - 1);

  logic [3:0]              botoes_s;
  estado_t                 estado;
  logic [LARGURA_CONT-1:0] cont;
  logic [3:0]              candidato;
  logic [3:0]              jogada;

  sincronizador_2ff #(
    .LARGURA(4)
  ) u_sinc (
    .clock(clock),
    .reset(reset),
    .d    (bus.botoes),
    .q    (botoes_s)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      estado    <= OCIOSO;
      cont      <= '0;
      candidato <= 4'd0;
      jogada    <= 4'd0;
    end else begin
      case (estado)
        OCIOSO: begin
          cont <= '0;
          if (one_hot4(botoes_s)) begin
            candidato <= botoes_s;
            estado    <= FILTRANDO;
          end else if (botoes_s != 4'd0) begin
            estado <= AGUARDA_SOLTURA;
          end
        end
        FILTRANDO: begin
          if (botoes_s != candidato) begin
            cont   <= '0;
            estado <= OCIOSO;
          end else if (cont == CONT_MAX) begin
            cont   <= '0;
            estado <= REGISTRA;
          end else begin
            cont <= cont + 1'b1;
          end
        end
        REGISTRA: begin
          if (bus.habilita)
            jogada <= candidato;
          cont   <= '0;
          estado <= AGUARDA_SOLTURA;
        end
        AGUARDA_SOLTURA: begin
          cont <= '0;
          if (botoes_s == 4'd0)
            estado <= FILTRA_SOLTURA;
        end
        FILTRA_SOLTURA: begin
          if (botoes_s != 4'd0) begin
            cont   <= '0;
            estado <= AGUARDA_SOLTURA;
          end else if (cont == CONT_MAX) begin
            cont   <= '0;
            estado <= OCIOSO;
          end else begin
            cont <= cont + 1'b1;
          end
        end
        default: begin
          cont   <= '0;
          estado <= OCIOSO;
        end
      endcase
    end
  end

  // Reset in the registra cycle swallows the pulse outright.
  assign bus.tem_jogada = (estado == REGISTRA) &&
                          bus.habilita && !reset;
  assign bus.jogada = jogada;

  always_comb begin
    bus.db_estado = DB_ILEGAL;
    case (estado)
      OCIOSO,
      FILTRANDO,
      REGISTRA,
      AGUARDA_SOLTURA,
      FILTRA_SOLTURA: bus.db_estado = estado;
      default:        bus.db_estado = DB_ILEGAL;
    endcase
  end

endmodule

// File: tb/tb_exp6_detector_jogada.sv
// Directed bench for the move detector, default N_DEBOUNCE.
// Each scenario task drives stimulus and checks inline.
module tb_exp6_detector_jogada;
  import exp6_constantes::*;

  localparam int N = N_DEBOUNCE_PADRAO;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  exp6_detector_jogada_if bus();

  exp6_detector_jogada #(
    .N_DEBOUNCE(N)
  ) dut (
    .clock(clk),
    .reset(reset),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;
  int ciclo = 0;
  int pulsos = 0;
  int ciclo_pulso = -1;
  logic tem_prev = 1'b0;
  logic [2:0] trace[$];

  always @(posedge clk) ciclo <= ciclo + 1;

  always @(negedge clk) begin
    if (bus.tem_jogada === 1'b1) begin
      pulsos = pulsos + 1;
      ciclo_pulso = ciclo;
      checks = checks + 1;
      if (tem_prev === 1'b1) begin
        errors = errors + 1;
        $display("FAIL pulse_width: tem_jogada high two cycles at %0d",
                 ciclo);
      end
    end
    tem_prev = bus.tem_jogada;
    if (trace.size() == 0 || trace[$] !== bus.db_estado)
      trace.push_back(bus.db_estado);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.botoes = 4'b0000;
    bus.habilita = 1'b1;
    step(3);
    checks++;
    if (bus.tem_jogada !== 1'b0) begin
      errors++;
      $display("FAIL reset_tem: got %b want 0", bus.tem_jogada);
    end
    checks++;
    if (bus.jogada !== 4'b0000) begin
      errors++;
      $display("FAIL reset_jogada: got %b want 0000", bus.jogada);
    end
    checks++;
    if (bus.db_estado !== 3'd0) begin
      errors++;
      $display("FAIL reset_db: got %0d want 0", bus.db_estado);
    end
    reset = 1'b0;
    step(2);
  endtask

  task automatic test_bounce;
    int p0;
    p0 = pulsos;
    bus.botoes = 4'b0001;
    step(3);
    bus.botoes = 4'b0000;
    step(10);
    checks++;
    if (pulsos !== p0) begin
      errors++;
      $display("FAIL bounce_pulse: got %0d pulses want 0", pulsos - p0);
    end
    checks++;
    if (bus.jogada !== 4'b0000) begin
      errors++;
      $display("FAIL bounce_jogada: got %b want 0000", bus.jogada);
    end
    checks++;
    if (bus.db_estado !== 3'd0) begin
      errors++;
      $display("FAIL bounce_db: got %0d want 0", bus.db_estado);
    end
  endtask

  task automatic test_press_accept;
    int p0;
    int t0;
    logic [2:0] esperado[6];
    esperado[0] = OCIOSO;
    esperado[1] = FILTRANDO;
    esperado[2] = REGISTRA;
    esperado[3] = AGUARDA_SOLTURA;
    esperado[4] = FILTRA_SOLTURA;
    esperado[5] = OCIOSO;
    trace.delete();
    trace.push_back(bus.db_estado);
    p0 = pulsos;
    t0 = ciclo;
    bus.botoes = 4'b0100;
    step(20);
    bus.botoes = 4'b0000;
    step(12);
    checks++;
    if (pulsos - p0 !== 1) begin
      errors++;
      $display("FAIL accept_count: got %0d pulses want 1", pulsos - p0);
    end
    checks++;
    if (ciclo_pulso !== t0 + N + 3) begin
      errors++;
      $display("FAIL accept_latency: pulse at %0d want %0d",
               ciclo_pulso, t0 + N + 3);
    end
    checks++;
    if (bus.jogada !== 4'b0100) begin
      errors++;
      $display("FAIL accept_jogada: got %b want 0100", bus.jogada);
    end
    checks++;
    if (trace.size() !== 6) begin
      errors++;
      $display("FAIL accept_trace_len: got %0d want 6", trace.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (trace[i] !== esperado[i]) begin
          errors++;
          $display("FAIL accept_trace[%0d]: got %0d want %0d",
                   i, trace[i], esperado[i]);
        end
      end
    end
  endtask

  task automatic test_multi;
    int p0;
    p0 = pulsos;
    bus.botoes = 4'b0011;
    step(10);
    checks++;
    if (bus.db_estado !== 3'd3) begin
      errors++;
      $display("FAIL multi_hold_db: got %0d want 3", bus.db_estado);
    end
    bus.botoes = 4'b0000;
    step(N + 2);
    checks++;
    if (bus.db_estado !== 3'd4) begin
      errors++;
      $display("FAIL multi_filter_db: got %0d want 4", bus.db_estado);
    end
    step(1);
    checks++;
    if (bus.db_estado !== 3'd0) begin
      errors++;
      $display("FAIL multi_idle_db: got %0d want 0", bus.db_estado);
    end
    checks++;
    if (pulsos !== p0) begin
      errors++;
      $display("FAIL multi_pulse: got %0d pulses want 0", pulsos - p0);
    end
  endtask

  task automatic test_disabled;
    int p0;
    p0 = pulsos;
    bus.habilita = 1'b0;
    bus.botoes = 4'b1000;
    step(12);
    bus.botoes = 4'b0000;
    step(12);
    bus.habilita = 1'b1;
    checks++;
    if (pulsos !== p0) begin
      errors++;
      $display("FAIL disabled_pulse: got %0d pulses want 0", pulsos - p0);
    end
    checks++;
    if (bus.jogada !== 4'b0100) begin
      errors++;
      $display("FAIL disabled_jogada: got %b want 0100", bus.jogada);
    end
    checks++;
    if (bus.db_estado !== 3'd0) begin
      errors++;
      $display("FAIL disabled_db: got %0d want 0", bus.db_estado);
    end
  endtask

  task automatic test_back_to_back;
    int p0;
    p0 = pulsos;
    bus.botoes = 4'b0010;
    step(10);
    bus.botoes = 4'b0000;
    step(1);
    bus.botoes = 4'b0010;
    step(1);
    bus.botoes = 4'b0000;
    step(14);
    checks++;
    if (pulsos - p0 !== 1) begin
      errors++;
      $display("FAIL glitch_count: got %0d pulses want 1", pulsos - p0);
    end
    checks++;
    if (bus.jogada !== 4'b0010) begin
      errors++;
      $display("FAIL glitch_jogada: got %b want 0010", bus.jogada);
    end
    bus.botoes = 4'b0001;
    step(10);
    bus.botoes = 4'b0000;
    step(12);
    checks++;
    if (pulsos - p0 !== 2) begin
      errors++;
      $display("FAIL second_count: got %0d pulses want 2", pulsos - p0);
    end
    checks++;
    if (bus.jogada !== 4'b0001) begin
      errors++;
      $display("FAIL second_jogada: got %b want 0001", bus.jogada);
    end
  endtask

  task automatic test_reset_in_registra;
    int p0;
    int tr;
    bit found;
    found = 1'b0;
    p0 = pulsos;
    bus.botoes = 4'b0100;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (bus.db_estado === 3'd2) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL rr_reach: db_estado %0d want 2 within 30",
               bus.db_estado);
    end
    reset = 1'b1;
    step(1);
    checks++;
    if (pulsos !== p0) begin
      errors++;
      $display("FAIL rr_suppress: got %0d pulses want 0", pulsos - p0);
    end
    checks++;
    if (bus.db_estado !== 3'd0 || bus.jogada !== 4'b0000) begin
      errors++;
      $display("FAIL rr_state: db %0d jogada %b want 0 0000",
               bus.db_estado, bus.jogada);
    end
    reset = 1'b0;
    tr = ciclo;
    step(14);
    checks++;
    if (pulsos - p0 !== 1) begin
      errors++;
      $display("FAIL rr_count: got %0d pulses want 1", pulsos - p0);
    end
    checks++;
    if (ciclo_pulso !== tr + 7) begin
      errors++;
      $display("FAIL rr_latency: pulse at %0d want %0d",
               ciclo_pulso, tr + 7);
    end
    checks++;
    if (bus.jogada !== 4'b0100) begin
      errors++;
      $display("FAIL rr_jogada: got %b want 0100", bus.jogada);
    end
    bus.botoes = 4'b0000;
    step(12);
  endtask

  initial begin
    bus.botoes = 4'b0000;
    bus.habilita = 1'b1;
    test_reset();
    test_bounce();
    test_press_accept();
    test_multi();
    test_disabled();
    test_back_to_back();
    test_reset_in_registra();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
